// File: rtl/rr_mux_stream.sv
// N-input stream multiplexer with its own arbiter and a registered output.
// Round-robin or fixed-priority; a grant is held until the packet's last beat.
module rr_mux_stream #(
    parameter int N           = 4,
    parameter int W           = 4,
    parameter int ROUND_ROBIN = 1,
    localparam int SW         = (N > 2) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [N-1:0]    I_valid,
    input  logic [N*W-1:0]  I_data,
    input  logic [N-1:0]    I_last,
    output logic [N-1:0]    I_ready,
    output logic            O_valid,
    output logic [W-1:0]    O_data,
    output logic            O_last,
    output logic [SW-1:0]   O_sel,
    input  logic            O_ready
);

    logic          o_valid_q, o_valid_d;
    logic [W-1:0]  o_data_q, o_data_d;
    logic          o_last_q, o_last_d;
    logic [SW-1:0] o_sel_q, o_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          locked_q, locked_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;

    logic          load;
    logic          gnt_found;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] base;
    logic [SW-1:0] cand;
    logic [SW:0]   sum;
    logic          xfer;

    // Scan from base modulo N; fixed priority is the same scan from 0.
    always_comb begin
        base      = (ROUND_ROBIN != 0) ? ptr_q : '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        if (locked_q) begin
            gnt_found = 1'b1;
            gnt_idx   = lock_ch_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, base} + (SW+1)'(k);
                if (sum >= (SW+1)'(N)) begin
                    sum = sum - (SW+1)'(N);
                end
                cand = sum[SW-1:0];
                if (!gnt_found && I_valid[cand]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign load = !o_valid_q || O_ready;
    assign xfer = load && gnt_found && I_valid[gnt_idx];

    always_comb begin
        I_ready = '0;
        for (int i = 0; i < N; i++) begin
            I_ready[i] = load && gnt_found && (gnt_idx == SW'(i));
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        o_sel_d   = o_sel_q;
        ptr_d     = ptr_q;
        locked_d  = locked_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = I_data[int'(gnt_idx)*W +: W];
            o_last_d  = I_last[gnt_idx];
            o_sel_d   = gnt_idx;
            if (I_last[gnt_idx]) begin
                locked_d = 1'b0;
                if (ROUND_ROBIN != 0) begin
                    ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
                end
            end else begin
                locked_d  = 1'b1;
                lock_ch_d = gnt_idx;
            end
        end else if (O_ready && o_valid_q) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_sel_q   <= '0;
            ptr_q     <= '0;
            locked_q  <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_sel_q   <= o_sel_d;
            ptr_q     <= ptr_d;
            locked_q  <= locked_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    assign O_valid = o_valid_q;
    assign O_data  = o_data_q;
    assign O_last  = o_last_q;
    assign O_sel   = o_sel_q;

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench: round-robin N=4, round-robin N=3 and fixed-priority N=4.
module tb_rr_mux_stream;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // instance A: N=4, round-robin
    logic [3:0]  a_valid, a_last, a_ready;
    logic [15:0] a_data;
    logic        a_ovalid, a_olast, a_oready;
    logic [3:0]  a_odata;
    logic [1:0]  a_osel;

    // instance B: N=3, round-robin
    logic [2:0]  b_valid, b_last, b_ready;
    logic [11:0] b_data;
    logic        b_ovalid, b_olast, b_oready;
    logic [3:0]  b_odata;
    logic [1:0]  b_osel;

    // instance C: N=4, fixed priority
    logic [3:0]  c_valid, c_last, c_ready;
    logic [15:0] c_data;
    logic        c_ovalid, c_olast, c_oready;
    logic [3:0]  c_odata;
    logic [1:0]  c_osel;

    rr_mux_stream #(.N(4), .W(4), .ROUND_ROBIN(1)) u_a (
        .CLK(clk), .RESET(rst),
        .I_valid(a_valid), .I_data(a_data), .I_last(a_last),
        .I_ready(a_ready),
        .O_valid(a_ovalid), .O_data(a_odata), .O_last(a_olast),
        .O_sel(a_osel), .O_ready(a_oready)
    );

    rr_mux_stream #(.N(3), .W(4), .ROUND_ROBIN(1)) u_b (
        .CLK(clk), .RESET(rst),
        .I_valid(b_valid), .I_data(b_data), .I_last(b_last),
        .I_ready(b_ready),
        .O_valid(b_ovalid), .O_data(b_odata), .O_last(b_olast),
        .O_sel(b_osel), .O_ready(b_oready)
    );

    rr_mux_stream #(.N(4), .W(4), .ROUND_ROBIN(0)) u_c (
        .CLK(clk), .RESET(rst),
        .I_valid(c_valid), .I_data(c_data), .I_last(c_last),
        .I_ready(c_ready),
        .O_valid(c_ovalid), .O_data(c_odata), .O_last(c_olast),
        .O_sel(c_osel), .O_ready(c_oready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic [3:0] d, input logic l);
        a_data[ch*4 +: 4] = d;
        a_last[ch]        = l;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] d);
        chk({tag, ".valid"}, 32'(a_ovalid), 32'(v));
        chk({tag, ".sel"},   32'(a_osel),   32'(s));
        chk({tag, ".data"},  32'(a_odata),  32'(d));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rot_sel [5];
        logic [3:0] rot_dat [5];
        logic [1:0] b_exp   [4];
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rot_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        b_exp   = '{2'd0, 2'd2, 2'd0, 2'd2};

        rst      = 1'b1;
        a_valid  = 4'b1111;
        a_last   = 4'b1111;
        a_data   = {4'hD, 4'hC, 4'hB, 4'hA};
        a_oready = 1'b1;
        b_valid  = '0;
        b_last   = '1;
        b_data   = '0;
        b_oready = 1'b1;
        c_valid  = '0;
        c_last   = '1;
        c_data   = '0;
        c_oready = 1'b1;

        // reset held for two edges with all channels offering
        tick();
        tick();
        chk("rst.a.valid", 32'(a_ovalid), 32'd0);
        chk("rst.a.data",  32'(a_odata),  32'd0);
        chk("rst.a.last",  32'(a_olast),  32'd0);
        chk("rst.a.sel",   32'(a_osel),   32'd0);
        chk("rst.b.valid", 32'(b_ovalid), 32'd0);
        chk("rst.c.valid", 32'(c_ovalid), 32'd0);
        chk("rst.a.ready", 32'(a_ready),  32'b0001);
        rst = 1'b0;
        #1;
        chk("rel.a.ready", 32'(a_ready),  32'b0001);
        chk("rel.a.valid", 32'(a_ovalid), 32'd0);

        // back-to-back rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a($sformatf("rot%0d", i), 1'b1, rot_sel[i], rot_dat[i]);
            chk($sformatf("rot%0d.last", i), 32'(a_olast), 32'd1);
        end
        a_valid = '0;
        tick();
        chk("drain.a.valid", 32'(a_ovalid), 32'd0);

        // packet lock on channel 1 (ptr is now 1)
        set_a(1, 4'h1, 1'b0);
        a_valid = 4'b0011;
        #1;
        chk("lk.b1.ready", 32'(a_ready), 32'b0010);
        tick();
        chk_a("lk.b1", 1'b1, 2'd1, 4'h1);
        chk("lk.b1.last", 32'(a_olast), 32'd0);
        set_a(1, 4'h2, 1'b0);
        #1;
        chk("lk.b2.ready", 32'(a_ready), 32'b0010);
        tick();
        chk_a("lk.b2", 1'b1, 2'd1, 4'h2);
        a_valid = 4'b0101;
        set_a(2, 4'h5, 1'b1);
        #1;
        chk("lk.stall.ready", 32'(a_ready), 32'b0010);
        tick();
        chk("lk.stall.valid", 32'(a_ovalid), 32'd0);
        a_valid = 4'b0111;
        set_a(1, 4'h3, 1'b1);
        tick();
        chk_a("lk.b3", 1'b1, 2'd1, 4'h3);
        chk("lk.b3.last", 32'(a_olast), 32'd1);
        a_valid = 4'b0101;
        #1;
        chk("lk.next.ready", 32'(a_ready), 32'b0100);
        tick();
        chk_a("lk.next", 1'b1, 2'd2, 4'h5);

        // backpressure: hold channel-2 beat for 4 cycles
        a_oready = 1'b0;
        #1;
        chk("bp.ready", 32'(a_ready), 32'b0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a($sformatf("bp%0d", i), 1'b1, 2'd2, 4'h5);
            chk($sformatf("bp%0d.ready", i), 32'(a_ready), 32'b0000);
        end
        a_oready = 1'b1;
        #1;
        chk("bp.rel.ready", 32'(a_ready), 32'b0001);
        tick();
        chk_a("bp.rel", 1'b1, 2'd0, 4'hA);
        a_valid = '0;
        tick();
        chk("bp.drain.valid", 32'(a_ovalid), 32'd0);

        // N=3 wrap with channels 0 and 2 valid
        b_data  = {4'h7, 4'h0, 4'h1};
        b_last  = 3'b111;
        b_valid = 3'b101;
        #1;
        chk("wr.ready0", 32'(b_ready), 32'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wr%0d.sel", i), 32'(b_osel), 32'(b_exp[i]));
            chk($sformatf("wr%0d.data", i), 32'(b_odata),
                (b_exp[i] == 2'd0) ? 32'h1 : 32'h7);
            chk($sformatf("wr%0d.ready", i), 32'(b_ready),
                (b_exp[i] == 2'd0) ? 32'b100 : 32'b001);
        end
        b_valid = '0;

        // fixed priority: channel 0 always wins
        c_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        c_last  = 4'b1111;
        c_valid = 4'b1111;
        #1;
        chk("fp.ready", 32'(c_ready), 32'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("fp%0d.sel", i), 32'(c_osel), 32'd0);
            chk($sformatf("fp%0d.data", i), 32'(c_odata), 32'h1);
            chk($sformatf("fp%0d.ready", i), 32'(c_ready), 32'b0001);
        end
        c_data[3:0] = 4'h9;
        c_last[0]   = 1'b0;
        tick();
        chk("fp.pk.sel",  32'(c_osel),  32'd0);
        chk("fp.pk.data", 32'(c_odata), 32'h9);
        chk("fp.pk.last", 32'(c_olast), 32'd0);
        c_valid = 4'b1110;
        #1;
        chk("fp.lock.ready", 32'(c_ready), 32'b0001);

        // reset mid-packet
        rst = 1'b1;
        #1;
        chk("fp.rst.ready", 32'(c_ready), 32'b0001);
        tick();
        chk("fp.rst.valid", 32'(c_ovalid), 32'd0);
        chk("fp.rst.data",  32'(c_odata),  32'd0);
        chk("fp.rst.sel",   32'(c_osel),   32'd0);
        chk("fp.rst.last",  32'(c_olast),  32'd0);
        rst = 1'b0;
        #1;
        chk("fp.unlock.ready", 32'(c_ready), 32'b0010);
        c_valid     = 4'b1111;
        c_data[3:0] = 4'h1;
        c_last[0]   = 1'b1;
        #1;
        chk("fp.restart.ready", 32'(c_ready), 32'b0001);
        tick();
        chk("fp.restart.sel",   32'(c_osel),   32'd0);
        chk("fp.restart.data",  32'(c_odata),  32'h1);
        chk("fp.restart.valid", 32'(c_ovalid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
